statedisc_normalizer_mc: RTL and testbench
==========================================

# statedisc_normalizer_mc

Multi-channel, configurable successor of the state-discriminator input normaliser. Takes accumulated I/Q pairs for `NCH` readout channels, adds a per-channel offset, applies a per-channel left shift with round-half-up truncation and saturation, and emits the `OUT_W`-bit pairs that feed the NN classifier. Configuration is double-buffered and commits only at frame start, so a frame is never processed with mixed settings. A frame-start marker is carried alongside the data.

## Interface
- `NCH`, 4, number of I/Q channels
- `IN_W`, 32, signed width of each accumulated I or Q word
- `OUT_W`, 18, signed width of each normalised I or Q word
- `SHIFT_W`, 5, width of the per-channel shift field (shift 0..2^SHIFT_W-1)
- `DROP`, 18, LSBs discarded after shifting
- `DEFAULT_SHIFT`, 11, shift loaded at reset
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `cfg_we` in 1: config write strobe
- `cfg_addr` in $clog2(NCH)+2: {channel, field}; field 0 = offset I, 1 = offset Q, 2 = shift (low `SHIFT_W` bits), 3 = ignored
- `cfg_wdata` in IN_W: signed offset or shift value
- `in_valid` in 1: input sample valid
- `in_start` in 1: first sample of a frame; only meaningful with `in_valid`
- `in_data` in NCH*2*IN_W: channel c at `[c*2*IN_W +: 2*IN_W]`, I in upper half, Q in lower half
- `out_valid` out 1: output valid
- `out_start` out 1: frame start aligned to `out_data`, drives NN start trigger
- `out_data` out NCH*2*OUT_W: same packing, `OUT_W` per word
- `sat_any` out 1: any word of the current `out_data` saturated
- `sat_count` out 16: cycles with `sat_any`, sticks at 0xFFFF
- `sat_clr` in 1: clears `sat_count`

## Operation
- Staging bank: `cfg_we` writes staging offset I/Q or shift for the addressed channel. Channel index >= `NCH` or field 3 is ignored.
- Active bank: copied from staging in the cycle `in_valid && in_start`. The copy uses staging contents from before that cycle's write. A simultaneous write lands in staging only and applies at the next frame start. The start sample itself is processed with the newly committed values.
- Per word: `s = data + offset`, computed in IN_W+1 bits with no wrap. `y = s << shift`, computed in IN_W+1+2^SHIFT_W-1 bits. `z = (y + 2^(DROP-1)) >>> DROP`, arithmetic shift (round half up). The result is saturated to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- With defaults, the operation equals round(s/128).
- No backpressure. Every valid input produces exactly one valid output.
- `sat_count` increments when `sat_any && out_valid`. It saturates at 0xFFFF. `sat_clr` wins over an increment in the same cycle.

## Timing
- Fixed latency of 4 cycles from the `in_valid` edge to `out_valid`:
  - S1: register inputs and active config
  - S2: add
  - S3: shift + round
  - S4: saturate
- `out_start` and `sat_any` are aligned with `out_valid`.
- Back-to-back inputs are accepted every cycle. Throughput is 1 sample/cycle.
- `out_data` holds its last value while `out_valid` = 0.
- Reset values:
  - `out_valid`, `out_start`, `sat_any`, `out_data`, `sat_count` = 0
  - all offsets = 0, all shifts = `DEFAULT_SHIFT`, in both banks
- Reset mid-operation drops in-flight samples: no `out_valid` for samples accepted before reset.
- A config write without a subsequent `in_start` never changes the output.

## Structure
- Package `statedisc_pkg`:
  - field enum (`FLD_OFS_I`, `FLD_OFS_Q`, `FLD_SHIFT`)
  - default parameter constants
  - `sat_count` width constant
- Sub-module `statedisc_norm_lane`: one I or Q word through S2–S4 (add/shift/round/saturate) plus a saturation flag. Instantiated 2*NCH times.
- The top level holds the config banks, valid/start pipeline and counter.

## Test plan
- Defaults: ch0 I=1000, offset I=24, start frame, one sample -> 4 cycles later `out_valid`=1, `out_start`=1, ch0 I out = 8. The `s`=64 case gives 1 and `s`=63 gives 0 (rounding).
- Saturation: I=0x7FFFFFFF, offset 0x7FFFFFFF -> out 131071, `sat_any`=1, `sat_count`=1. I=0x80000000 with offset -1 -> -131072.
- Config commit: write ch2 shift=13 mid-frame -> unchanged output. At next `in_start`, ch2 words are 4x the prior value. A write issued in the same cycle as `in_start` takes effect only at the following frame.
- Streaming: 64 back-to-back samples with `in_start` on the first -> 64 consecutive `out_valid`, single `out_start`, data matches the reference model.
- Reset mid-stream: assert `rst` with 3 samples in flight -> all outputs 0 the next cycle, no stale `out_valid`, shifts back to 11.
- Counter: force `sat_count` near 0xFFFF -> holds at 0xFFFF. `sat_clr` with a simultaneous saturation -> 0.

Source files
------------

// File: rtl/statedisc_pkg.sv
// Shared constants and config field encoding for the multi-channel
// state-discriminator input normaliser.
package statedisc_pkg;

  localparam int NCH_DEF           = 4;
  localparam int IN_W_DEF          = 32;
  localparam int OUT_W_DEF         = 18;
  localparam int SHIFT_W_DEF       = 5;
  localparam int DROP_DEF          = 18;
  localparam int DEFAULT_SHIFT_DEF = 11;

  localparam int SAT_CNT_W = 16;

  // Low two bits of cfg_addr select which per-channel field is written.
  typedef enum logic [1:0] {
    FLD_OFS_I = 2'd0,
    FLD_OFS_Q = 2'd1,
    FLD_SHIFT = 2'd2,
    FLD_RSVD  = 2'd3
  } field_e;

endpackage

// File: rtl/statedisc_norm_lane.sv
// One I or Q word through add (S2), shift + round-half-up (S3) and
// saturate (S4). The S4 result only updates when upd is high, so it holds.
module statedisc_norm_lane
  import statedisc_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int DROP    = DROP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    data,
  input  logic [IN_W-1:0]    offset,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               upd,
  output logic [OUT_W-1:0]   result,
  output logic               sat
);

  localparam int S_W = IN_W + 1;
  localparam int Y_W = S_W + (1 << SHIFT_W) - 1;
  localparam int R_W = Y_W + 1;
  localparam int Z_W = R_W - DROP;

  localparam logic [R_W-1:0] RND = R_W'(1) << (DROP - 1);
  localparam logic signed [Z_W-1:0] Z_MAX = {{(Z_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [Z_W-1:0] Z_MIN = {{(Z_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [S_W-1:0] s_reg;
  logic [SHIFT_W-1:0]    shift_reg;
  logic signed [Z_W-1:0] z_reg;
  logic [Y_W-1:0]        y;
  logic [R_W-1:0]        r;

  // Both widths are large enough that neither the shift nor the rounding add can wrap.
  always_comb begin
    y = {{(Y_W-S_W){s_reg[S_W-1]}}, s_reg} << shift_reg;
    r = {y[Y_W-1], y} + RND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg     <= '0;
      shift_reg <= '0;
      z_reg     <= '0;
      result    <= '0;
      sat       <= 1'b0;
    end else begin
      s_reg     <= {data[IN_W-1], data} + {offset[IN_W-1], offset};
      shift_reg <= shift;
      z_reg     <= r[R_W-1:DROP];
      if (upd) begin
        if (z_reg > Z_MAX) begin
          result <= OUT_MAX;
          sat    <= 1'b1;
        end else if (z_reg < Z_MIN) begin
          result <= OUT_MIN;
          sat    <= 1'b1;
        end else begin
          result <= z_reg[OUT_W-1:0];
          sat    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/statedisc_normalizer_mc.sv
// Multi-channel I/Q normaliser: double-buffered per-channel offset/shift,
// 4-stage pipeline feeding the NN classifier, and a saturation counter.
module statedisc_normalizer_mc
  import statedisc_pkg::*;
#(
  parameter int NCH           = NCH_DEF,
  parameter int IN_W          = IN_W_DEF,
  parameter int OUT_W         = OUT_W_DEF,
  parameter int SHIFT_W       = SHIFT_W_DEF,
  parameter int DROP          = DROP_DEF,
  parameter int DEFAULT_SHIFT = DEFAULT_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)+1:0]   cfg_addr,
  input  logic [IN_W-1:0]          cfg_wdata,
  input  logic                     in_valid,
  input  logic                     in_start,
  input  logic [NCH*2*IN_W-1:0]    in_data,
  output logic                     out_valid,
  output logic                     out_start,
  output logic [NCH*2*OUT_W-1:0]   out_data,
  output logic                     sat_any,
  output logic [SAT_CNT_W-1:0]     sat_count,
  input  logic                     sat_clr
);

  localparam int CH_W = $clog2(NCH);
  localparam logic [SHIFT_W-1:0] SHIFT_RST = SHIFT_W'(DEFAULT_SHIFT);

  logic [CH_W-1:0] cfg_ch;
  field_e          cfg_fld;
  logic            cfg_hit;
  logic            commit;

  assign cfg_ch  = cfg_addr[CH_W+1:2];
  assign cfg_fld = field_e'(cfg_addr[1:0]);
  assign cfg_hit = cfg_we && (int'({1'b0, cfg_ch}) < NCH);
  assign commit  = in_valid && in_start;

  logic [IN_W-1:0]    stg_ofs_i_reg [NCH];
  logic [IN_W-1:0]    stg_ofs_q_reg [NCH];
  logic [SHIFT_W-1:0] stg_shift_reg [NCH];
  logic [IN_W-1:0]    act_ofs_i_reg [NCH];
  logic [IN_W-1:0]    act_ofs_q_reg [NCH];
  logic [SHIFT_W-1:0] act_shift_reg [NCH];

  // Non-blocking copy means a write in the commit cycle stays in staging only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        stg_ofs_i_reg[c] <= '0;
        stg_ofs_q_reg[c] <= '0;
        stg_shift_reg[c] <= SHIFT_RST;
        act_ofs_i_reg[c] <= '0;
        act_ofs_q_reg[c] <= '0;
        act_shift_reg[c] <= SHIFT_RST;
      end
    end else begin
      if (commit) begin
        for (int c = 0; c < NCH; c++) begin
          act_ofs_i_reg[c] <= stg_ofs_i_reg[c];
          act_ofs_q_reg[c] <= stg_ofs_q_reg[c];
          act_shift_reg[c] <= stg_shift_reg[c];
        end
      end
      if (cfg_hit) begin
        case (cfg_fld)
          FLD_OFS_I: stg_ofs_i_reg[cfg_ch] <= cfg_wdata;
          FLD_OFS_Q: stg_ofs_q_reg[cfg_ch] <= cfg_wdata;
          FLD_SHIFT: stg_shift_reg[cfg_ch] <= cfg_wdata[SHIFT_W-1:0];
          default:   ;
        endcase
      end
    end
  end

  logic [NCH*2*IN_W-1:0] s1_data_reg;
  logic s1_valid_reg, s2_valid_reg, s3_valid_reg, out_valid_reg;
  logic s1_start_reg, s2_start_reg, s3_start_reg, out_start_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_reg   <= '0;
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s3_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      s1_start_reg  <= 1'b0;
      s2_start_reg  <= 1'b0;
      s3_start_reg  <= 1'b0;
      out_start_reg <= 1'b0;
    end else begin
      s1_data_reg   <= in_data;
      s1_valid_reg  <= in_valid;
      s2_valid_reg  <= s1_valid_reg;
      s3_valid_reg  <= s2_valid_reg;
      out_valid_reg <= s3_valid_reg;
      s1_start_reg  <= commit;
      s2_start_reg  <= s1_start_reg;
      s3_start_reg  <= s2_start_reg;
      out_start_reg <= s3_start_reg;
    end
  end

  logic [2*NCH-1:0] lane_sat;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [IN_W-1:0]    s1_ofs_i_reg;
      logic [IN_W-1:0]    s1_ofs_q_reg;
      logic [SHIFT_W-1:0] s1_shift_reg;

      // The start sample sees the bank being committed in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_ofs_i_reg <= '0;
          s1_ofs_q_reg <= '0;
          s1_shift_reg <= SHIFT_RST;
        end else begin
          s1_ofs_i_reg <= commit ? stg_ofs_i_reg[gi] : act_ofs_i_reg[gi];
          s1_ofs_q_reg <= commit ? stg_ofs_q_reg[gi] : act_ofs_q_reg[gi];
          s1_shift_reg <= commit ? stg_shift_reg[gi] : act_shift_reg[gi];
        end
      end

      statedisc_norm_lane #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W),
        .DROP    (DROP)
      ) u_lane_i (
        .clk    (clk),
        .rst    (rst),
        .data   (s1_data_reg[(2*gi+1)*IN_W +: IN_W]),
        .offset (s1_ofs_i_reg),
        .shift  (s1_shift_reg),
        .upd    (s3_valid_reg),
        .result (out_data[(2*gi+1)*OUT_W +: OUT_W]),
        .sat    (lane_sat[2*gi+1])
      );

      statedisc_norm_lane #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W),
        .DROP    (DROP)
      ) u_lane_q (
        .clk    (clk),
        .rst    (rst),
        .data   (s1_data_reg[(2*gi)*IN_W +: IN_W]),
        .offset (s1_ofs_q_reg),
        .shift  (s1_shift_reg),
        .upd    (s3_valid_reg),
        .result (out_data[(2*gi)*OUT_W +: OUT_W]),
        .sat    (lane_sat[2*gi])
      );
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_start = out_start_reg;
  assign sat_any   = out_valid_reg && (|lane_sat);

  logic [SAT_CNT_W-1:0] sat_count_reg;

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_count_reg <= '0;
    end else if (sat_any && (sat_count_reg != '1)) begin
      sat_count_reg <= sat_count_reg + 1'b1;
    end
  end

  assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_statedisc_normalizer_mc.sv
// Scoreboard bench for statedisc_normalizer_mc: randomized stimulus against
// an arithmetic reference model, checked by an independent output monitor.
module tb_statedisc_normalizer_mc;
  import statedisc_pkg::*;

  localparam int NCH = 4, IN_W = 32, OUT_W = 18, SHIFT_W = 5, DROP = 18, DSH = 11;
  localparam int AW = $clog2(NCH) + 2;
  localparam int DW = NCH * 2 * IN_W;
  localparam int OW = NCH * 2 * OUT_W;

  logic clk, rst, cfg_we, in_valid, in_start, sat_clr;
  logic [AW-1:0] cfg_addr;
  logic [IN_W-1:0] cfg_wdata;
  logic [DW-1:0] in_data;
  logic out_valid, out_start, sat_any;
  logic [OW-1:0] out_data;
  logic [15:0] sat_count;

  statedisc_normalizer_mc #(
    .NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .DROP(DROP), .DEFAULT_SHIFT(DSH)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .out_valid(out_valid), .out_start(out_start), .out_data(out_data),
    .sat_any(sat_any), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    bit            start;
    bit            sat;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  longint m_stg_ofs [NCH][2];
  int     m_stg_sh  [NCH];
  longint m_act_ofs [NCH][2];
  int     m_act_sh  [NCH];
  int n_pass = 0, n_total = 0;
  int cyc = 0;
  bit quiet = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h (cyc %0d)", name, act, req, cyc);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_stg_ofs[c][0] = 0; m_stg_ofs[c][1] = 0; m_stg_sh[c] = DSH;
      m_act_ofs[c][0] = 0; m_act_ofs[c][1] = 0; m_act_sh[c] = DSH;
    end
  endfunction

  function automatic longint fdiv(input longint a, input longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // round_half_up((d+ofs) * 2^sh / 2^DROP), then clamp to OUT_W signed.
  function automatic void ref_word(input longint d, input longint ofs, input int sh,
                                   output logic [OUT_W-1:0] w, output bit sat);
    longint s, r, vmax, vmin;
    s = d + ofs;
    if (sh >= DROP) r = s * (longint'(1) << (sh - DROP));
    else r = fdiv(2 * s + (longint'(1) << (DROP - sh)), longint'(1) << (DROP - sh + 1));
    vmax = (longint'(1) << (OUT_W - 1)) - 1;
    vmin = -(longint'(1) << (OUT_W - 1));
    sat = (r > vmax) || (r < vmin);
    if (r > vmax) r = vmax;
    if (r < vmin) r = vmin;
    w = r[OUT_W-1:0];
  endfunction

  function automatic logic [IN_W-1:0] rnd_word();
    logic [IN_W-1:0] w;
    if ($urandom_range(3) == 0) return $urandom();
    w = $urandom_range(0, 2097151);
    return w - 32'd1048576;
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] r;
    for (int w = 0; w < 2 * NCH; w++) r[w*IN_W +: IN_W] = rnd_word();
    return r;
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] v, input int ch, input bit is_i,
                                        input logic [IN_W-1:0] w);
    logic [DW-1:0] r = v;
    r[(2*ch + int'(is_i))*IN_W +: IN_W] = w;
    return r;
  endfunction

  function automatic logic [AW-1:0] adr(input int ch, input int fld);
    return AW'(ch * 4 + fld);
  endfunction

  task automatic step(input bit v, input bit st, input logic [DW-1:0] d, input bit we,
                      input logic [AW-1:0] a, input logic [IN_W-1:0] wd, input bit clr);
    exp_t e;
    logic [OUT_W-1:0] wv;
    logic [IN_W-1:0] dw;
    bit s;
    int ch;
    @(negedge clk);
    in_valid = v; in_start = st; in_data = d;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd; sat_clr = clr;
    if (v) begin
      if (st) begin
        m_act_ofs = m_stg_ofs;
        m_act_sh  = m_stg_sh;
      end
      e.data = '0; e.sat = 0; e.start = st; e.cyc = cyc;
      for (int c = 0; c < NCH; c++) begin
        for (int h = 0; h < 2; h++) begin
          dw = d[(2*c+h)*IN_W +: IN_W];
          ref_word(longint'($signed(dw)), m_act_ofs[c][h], m_act_sh[c], wv, s);
          e.data[(2*c+h)*OUT_W +: OUT_W] = wv;
          e.sat = e.sat | s;
        end
      end
      sb.push_back(e);
    end
    if (we) begin
      ch = int'(a[AW-1:2]);
      if (ch < NCH) begin
        case (a[1:0])
          2'd0: m_stg_ofs[ch][1] = longint'($signed(wd));
          2'd1: m_stg_ofs[ch][0] = longint'($signed(wd));
          2'd2: m_stg_sh[ch] = int'(wd[SHIFT_W-1:0]);
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic wcfg(input int ch, input int fld, input logic [IN_W-1:0] val);
    step(0, 0, '0, 1, adr(ch, fld), val, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; in_start = 0; cfg_we = 0; sat_clr = 0;
    sb.delete();
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // Output monitor: pops the scoreboard whenever the DUT presents a sample.
  exp_t me;
  logic [15:0] m_cnt = 0;
  bit prev_inc = 0;
  logic [OW-1:0] last_data = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        m_cnt = 0; prev_inc = 0; last_data = '0;
        chk("reset_flags", OW'({out_valid, out_start, sat_any, sat_count}), OW'(0));
        chk("reset_data", out_data, '0);
      end else begin
        if (sat_clr) m_cnt = 0;
        else if (prev_inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        chk("sat_count", OW'(sat_count), OW'(m_cnt));
        prev_inc = 0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", OW'(1), OW'(0));
          end else begin
            me = sb.pop_front();
            chk("out_data", out_data, me.data);
            chk("out_start", OW'(out_start), OW'(me.start));
            chk("sat_any", OW'(sat_any), OW'(me.sat));
            chk("latency", OW'(cyc - me.cyc), OW'(4));
            prev_inc = me.sat;
            if (!quiet)
              $display("out cyc=%0d start=%0b sat=%0b cnt=%0d data=%h", cyc, out_start, sat_any,
                       sat_count, out_data);
          end
          last_data = out_data;
        end else begin
          chk("idle_out_start", OW'(out_start), OW'(0));
          chk("hold_out_data", out_data, last_data);
        end
      end
    end
  end

  logic [DW-1:0] d;
  int t;

  initial begin
    rst = 1; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 0; in_start = 0; in_data = '0; sat_clr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    idle();

    // Defaults: 1000+24 -> 8, then s=64 -> 1 and s=63 -> 0.
    wcfg(0, 0, 32'd24);
    d = put(rnd_vec(), 0, 1, 32'd1000);
    step(1, 1, d, 0, '0, '0, 0);
    step(1, 0, put(rnd_vec(), 0, 1, 32'd40), 0, '0, '0, 0);
    step(1, 0, put(rnd_vec(), 0, 1, 32'd39), 0, '0, '0, 0);
    repeat (5) idle();

    // Saturation at both rails.
    wcfg(1, 0, 32'h7FFFFFFF);
    wcfg(1, 1, 32'hFFFFFFFF);
    d = put(put('0, 1, 1, 32'h7FFFFFFF), 1, 0, 32'h80000000);
    step(1, 1, d, 0, '0, '0, 0);
    repeat (5) idle();

    // Config commit: mid-frame write is invisible until the next start.
    d = put(put('0, 2, 1, 32'd5000), 2, 0, 32'hFFFFEC78);
    step(1, 1, d, 0, '0, '0, 0);
    wcfg(2, 2, 32'd13);
    step(1, 0, d, 0, '0, '0, 0);
    step(1, 1, d, 1, adr(3, 2), 32'd9, 0);
    step(1, 0, put(d, 3, 1, 32'd77777), 0, '0, '0, 0);
    step(1, 1, put(d, 3, 1, 32'd77777), 0, '0, '0, 0);
    repeat (5) idle();

    // Streaming with random config traffic.
    for (int i = 0; i < 64; i++) begin
      bit we;
      logic [AW-1:0] a;
      logic [IN_W-1:0] wd;
      we = ($urandom_range(3) == 0);
      a = AW'($urandom_range(0, 15));
      wd = (a[1:0] == 2'd2) ? IN_W'($urandom_range(0, 31)) : rnd_word();
      step(1, i == 0, rnd_vec(), we, a, wd, 0);
    end
    repeat (5) idle();

    // Reset with samples in flight, then defaults must be back.
    wcfg(0, 2, 32'd20);
    step(1, 1, rnd_vec(), 0, '0, '0, 0);
    step(1, 0, rnd_vec(), 0, '0, '0, 0);
    step(1, 0, rnd_vec(), 0, '0, '0, 0);
    do_reset();
    step(1, 0, put(rnd_vec(), 0, 1, 32'd1000), 0, '0, '0, 0);
    step(1, 1, put(rnd_vec(), 0, 1, 32'd64), 0, '0, '0, 0);
    repeat (6) idle();

    // Counter: drive it into the 0xFFFF ceiling, then clear under saturation.
    quiet = 1;
    wcfg(0, 0, 32'h7FFFFFFF);
    d = put(rnd_vec(), 0, 1, 32'h7FFFFFFF);
    step(1, 1, d, 0, '0, '0, 0);
    for (int i = 0; i < 65540; i++) step(1, 0, d, 0, '0, '0, 0);
    quiet = 0;
    step(1, 0, d, 0, '0, '0, 0);
    step(1, 0, d, 0, '0, '0, 1);
    step(1, 0, d, 0, '0, '0, 0);
    step(1, 0, d, 0, '0, '0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, rnd_vec(), 0, '0, '0, ($urandom_range(4) == 0));

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      idle();
      t++;
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL drain: %0d outputs outstanding, required 0", sb.size());
    else n_pass++;
    repeat (2) idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
